sum_tree_stage: RTL and testbench

SUM_TREE_STAGE -- requirements
Module: sum_tree_stage

---
 rtl/sum_tree_stage.sv | 103 ++++++++++
 tb/tb_sum_tree_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sum_tree_stage.sv
// Pipelined N-operand adder tree: one register per tree level plus a registered format/overflow stage.
// Optional build macro SUM_TREE_STAGE_SAT_EN clamps overflowing results instead of wrapping.
module sum_tree_stage #(
  parameter int N      = 9,
  parameter int IN_W   = 16,
  parameter int OUT_W  = 16,
  parameter int SIGNED = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N*IN_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [OUT_W-1:0]    out_data,
  output logic                out_ovf,
  output logic                out_valid,
  input  logic                out_ready
);
  localparam int D  = $clog2(N);
  localparam int FW = IN_W + D;

  // Operand count surviving at tree level l.
  function automatic int cnt(input int l);
    return (N + (1 << l) - 1) >> l;
  endfunction

  logic              en;
  logic [D:0]        vld_pipe_q;
  logic [FW-1:0]     stage_q [1:D][0:N-1];
  logic [FW-1:0]     stage_d [1:D][0:N-1];
  logic [FW-1:0]     lvl     [0:D-1][0:2*N-1];
  logic [FW-1:0]     sum;
  logic [OUT_W-1:0]  out_data_d, out_data_q;
  logic              ovf_d, ovf_q;

  assign out_valid = vld_pipe_q[D];
  assign en        = !out_valid | out_ready;
  assign in_ready  = en;
  assign out_data  = out_data_q;
  assign out_ovf   = ovf_q;
  assign sum       = stage_q[D][0];

  // lvl is a zero-padded view of each level's inputs so pair indices never leave range.
  always_comb begin
    for (int l = 0; l < D; l++)
      for (int j = 0; j < 2*N; j++)
        lvl[l][j] = '0;
    for (int k = 0; k < N; k++)
      lvl[0][k] = (SIGNED != 0) ? FW'($signed(in_data[k*IN_W +: IN_W]))
                                : FW'(in_data[k*IN_W +: IN_W]);
    for (int l = 1; l < D; l++)
      for (int j = 0; j < N; j++)
        lvl[l][j] = stage_q[l][j];
    for (int l = 1; l <= D; l++)
      for (int j = 0; j < N; j++) begin
        stage_d[l][j] = '0;
        if (j < cnt(l))
          stage_d[l][j] = (2*j+1 < cnt(l-1)) ? lvl[l-1][2*j] + lvl[l-1][2*j+1]
                                             : lvl[l-1][2*j];
      end
  end

  generate
    if (OUT_W >= FW) begin : g_wide
      always_comb begin
        out_data_d = (SIGNED != 0) ? OUT_W'($signed(sum)) : OUT_W'(sum);
        ovf_d      = 1'b0;
      end
    end else begin : g_narrow
      // Bits above the result; signed fits only if they all match the result's sign bit.
      logic [FW-OUT_W:0] top;
      assign top = sum[FW-1:OUT_W-1];
`ifdef SUM_TREE_STAGE_SAT_EN
      localparam logic [OUT_W-1:0] SMIN = OUT_W'(1) << (OUT_W-1);
      localparam logic [OUT_W-1:0] SMAX = ~SMIN;
`endif
      always_comb begin
        ovf_d      = (SIGNED != 0) ? !((&top) || (~|top)) : (|top[FW-OUT_W:1]);
        out_data_d = sum[OUT_W-1:0];
`ifdef SUM_TREE_STAGE_SAT_EN
        if (ovf_d)
          out_data_d = (SIGNED != 0) ? (sum[FW-1] ? SMIN : SMAX) : '1;
`endif
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe_q <= '0;
      out_data_q <= '0;
      ovf_q      <= 1'b0;
      for (int l = 1; l <= D; l++)
        for (int j = 0; j < N; j++)
          stage_q[l][j] <= '0;
    end else if (en) begin
      vld_pipe_q <= {vld_pipe_q[D-1:0], in_valid};
      stage_q    <= stage_d;
      out_data_q <= out_data_d;
      ovf_q      <= ovf_d;
    end
  end
endmodule

// File: tb/tb_sum_tree_stage.sv
// Bench for sum_tree_stage: scoreboarded stream/backpressure/reset on N=9, plus directed
// latency/overflow sequences on four other configurations.
module tb_sum_tree_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // DUT A: N=9, IN_W=8, OUT_W=16, unsigned
  logic [71:0] a_din = '0;
  logic        a_iv = 1'b0, a_ordy = 1'b1;
  logic        a_ir, a_ov, a_of;
  logic [15:0] a_dout;
  sum_tree_stage #(.N(9), .IN_W(8), .OUT_W(16), .SIGNED(0)) u_a (
    .clk(clk), .rst(rst), .in_data(a_din), .in_valid(a_iv), .in_ready(a_ir),
    .out_data(a_dout), .out_ovf(a_of), .out_valid(a_ov), .out_ready(a_ordy));

  // DUTs B..E share in_valid; out_ready tied high
  logic         x_iv = 1'b0;
  logic [71:0]  b_din = '0;
  logic [143:0] c_din = '0;
  logic [7:0]   d_din = '0;
  logic [63:0]  e_din = '0;
  logic [7:0]   b_dout, d_dout, e_dout;
  logic [15:0]  c_dout;
  logic [3:0]   x_ir, x_ov, x_of;
  logic [15:0]  xo [4];

  sum_tree_stage #(.N(9), .IN_W(8), .OUT_W(8), .SIGNED(0)) u_b (
    .clk(clk), .rst(rst), .in_data(b_din), .in_valid(x_iv), .in_ready(x_ir[0]),
    .out_data(b_dout), .out_ovf(x_of[0]), .out_valid(x_ov[0]), .out_ready(1'b1));
  sum_tree_stage #(.N(9), .IN_W(16), .OUT_W(16), .SIGNED(1)) u_c (
    .clk(clk), .rst(rst), .in_data(c_din), .in_valid(x_iv), .in_ready(x_ir[1]),
    .out_data(c_dout), .out_ovf(x_of[1]), .out_valid(x_ov[1]), .out_ready(1'b1));
  sum_tree_stage #(.N(2), .IN_W(4), .OUT_W(8), .SIGNED(0)) u_d (
    .clk(clk), .rst(rst), .in_data(d_din), .in_valid(x_iv), .in_ready(x_ir[2]),
    .out_data(d_dout), .out_ovf(x_of[2]), .out_valid(x_ov[2]), .out_ready(1'b1));
  sum_tree_stage #(.N(16), .IN_W(4), .OUT_W(8), .SIGNED(0)) u_e (
    .clk(clk), .rst(rst), .in_data(e_din), .in_valid(x_iv), .in_ready(x_ir[3]),
    .out_data(e_dout), .out_ovf(x_of[3]), .out_valid(x_ov[3]), .out_ready(1'b1));

  assign xo[0] = {8'h00, b_dout};
  assign xo[1] = c_dout;
  assign xo[2] = {8'h00, d_dout};
  assign xo[3] = {8'h00, e_dout};

  logic [15:0] sbq [$];

  function automatic logic [15:0] sum9(input logic [71:0] v);
    logic [15:0] s = '0;
    for (int k = 0; k < 9; k++) s = s + {8'h00, v[8*k +: 8]};
    return s;
  endfunction

  // Scoreboard monitor for DUT A: every output transfer pops one expected sum.
  always @(negedge clk) begin
    if (rst && a_ov && a_ordy) begin
      if (sbq.size() == 0) chk("a_spurious_valid", {31'd0, a_ov}, 32'd0);
      else begin
        chk("a_data", {16'd0, a_dout}, {16'd0, sbq.pop_front()});
        chk("a_ovf", {31'd0, a_of}, 32'd0);
      end
    end
  end

  logic [71:0] vecs [10];
  logic [71:0] v;
  logic [15:0] held;
  logic [15:0] xexp [4][4];
  logic        xovf [4][4];
  int          xlat [4];
  int          lat, acc;

  initial begin
    // B: N=9 8b -> 8b unsigned
    xexp[0][0] = 16'd247; xovf[0][0] = 1'b1;
    xexp[0][1] = 16'd45;  xovf[0][1] = 1'b0;
    xexp[0][2] = 16'd255; xovf[0][2] = 1'b0;
    xexp[0][3] = 16'd0;   xovf[0][3] = 1'b1;
    // C: N=9 16b signed
    xexp[1][0] = 16'hFFF7; xovf[1][0] = 1'b0;
    xexp[1][1] = 16'h8000; xovf[1][1] = 1'b1;
    xexp[1][2] = 16'h7FF7; xovf[1][2] = 1'b1;
    xexp[1][3] = 16'h7FFF; xovf[1][3] = 1'b0;
`ifdef SUM_TREE_STAGE_SAT_EN
    xexp[0][0] = 16'd255;
    xexp[0][3] = 16'd255;
    xexp[1][2] = 16'h7FFF;
`endif
    xexp[2][0] = 16'd30;  xexp[2][1] = 16'd15; xexp[2][2] = 16'd0;  xexp[2][3] = 16'd15;
    xexp[3][0] = 16'd240; xexp[3][1] = 16'd0;  xexp[3][2] = 16'd16; xexp[3][3] = 16'd120;
    for (int i = 0; i < 4; i++) begin xovf[2][i] = 1'b0; xovf[3][i] = 1'b0; end
    xlat = '{5, 5, 2, 5};

    // Reset state
    #1;
    chk("rst_a_valid", {31'd0, a_ov}, 32'd0);
    chk("rst_a_data", {16'd0, a_dout}, 32'd0);
    chk("rst_a_ovf", {31'd0, a_of}, 32'd0);
    chk("rst_a_ready", {31'd0, a_ir}, 32'd1);
    chk("rst_x_valid", {28'd0, x_ov}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Operands 1..9 -> 45, latency 5 edges counting the accept edge
    for (int k = 0; k < 9; k++) v[8*k +: 8] = 8'(k + 1);
    @(posedge clk); #1;
    a_din = v; a_iv = 1'b1;
    chk("a_ready_idle", {31'd0, a_ir}, 32'd1);
    sbq.push_back(sum9(v));
    @(posedge clk); #1 a_iv = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!a_ov && lat < 20) begin @(posedge clk); lat++; @(negedge clk); end
    chk("a_latency", lat, 32'd5);

    // Back-to-back stream of 10 with out_ready low for 3 cycles
    for (int i = 0; i < 10; i++)
      for (int k = 0; k < 9; k++) vecs[i][8*k +: 8] = 8'($urandom);
    acc = 0;
    for (int c = 0; c < 40 && acc < 10; c++) begin
      @(posedge clk); #1;
      a_ordy = !(c >= 6 && c < 9);
      a_din = vecs[acc]; a_iv = 1'b1;
      @(negedge clk);
      if (c >= 6 && c < 9) begin
        chk("a_stall_ready", {31'd0, a_ir}, 32'd0);
        if (c == 6) held = a_dout;
        else chk("a_stall_hold", {16'd0, a_dout}, {16'd0, held});
      end
      if (a_ir) begin sbq.push_back(sum9(vecs[acc])); acc++; end
    end
    @(posedge clk); #1 a_iv = 1'b0; a_ordy = 1'b1;
    chk("a_stream_accepted", acc, 32'd10);
    for (int g = 0; g < 30 && sbq.size() != 0; g++) @(negedge clk);
    chk("a_stream_drain", sbq.size(), 32'd0);

    // Reset with vectors in flight
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      a_din = vecs[i]; a_iv = 1'b1;
      sbq.push_back(sum9(vecs[i]));
    end
    @(posedge clk); #1 a_iv = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("a_inflight_cnt", sbq.size(), 32'd2);
    chk("a_rst_valid", {31'd0, a_ov}, 32'd0);
    chk("a_rst_data", {16'd0, a_dout}, 32'd0);
    chk("a_rst_ready", {31'd0, a_ir}, 32'd1);
    sbq.delete();
    @(posedge clk); #1 rst = 1'b1;
    for (int i = 0; i < 8; i++) begin @(negedge clk); chk("a_no_stale", {31'd0, a_ov}, 32'd0); end
    @(posedge clk); #1;
    a_din = vecs[9]; a_iv = 1'b1;
    sbq.push_back(sum9(vecs[9]));
    @(posedge clk); #1 a_iv = 1'b0;
    for (int g = 0; g < 20 && sbq.size() != 0; g++) @(negedge clk);
    chk("a_post_rst_drain", sbq.size(), 32'd0);

    // Directed sequences on B..E: 4 vectors back-to-back, then watch valid/data per edge
    for (int t = 0; t < 11; t++) begin
      @(posedge clk); #1;
      b_din = '0; c_din = '0; d_din = '0; e_din = '0;
      x_iv = (t < 4);
      case (t)
        0: begin
          for (int k = 0; k < 9; k++) begin b_din[8*k +: 8] = 8'hFF; c_din[16*k +: 16] = 16'hFFFF; end
          d_din = 8'hFF; e_din = '1;
        end
        1: begin
          for (int k = 0; k < 9; k++) begin b_din[8*k +: 8] = 8'(k + 1); c_din[16*k +: 16] = 16'h8000; end
          d_din = 8'h0F;
        end
        2: begin
          b_din[7:0] = 8'hFF;
          for (int k = 0; k < 9; k++) c_din[16*k +: 16] = 16'h7FFF;
          for (int k = 0; k < 16; k++) e_din[4*k +: 4] = 4'd1;
        end
        3: begin
          b_din[15:0] = 16'h01FF; c_din[15:0] = 16'h7FFF; d_din = 8'h87;
          for (int k = 0; k < 16; k++) e_din[4*k +: 4] = 4'(k);
        end
        default: ;
      endcase
      @(negedge clk);
      if (t == 0) chk("x_ready", {28'd0, x_ir}, 32'hF);
      for (int d = 0; d < 4; d++) begin
        int idx;
        idx = t - xlat[d];
        chk($sformatf("x%0d_valid_t%0d", d, t), {31'd0, x_ov[d]}, {31'd0, (idx >= 0 && idx < 4)});
        if (idx >= 0 && idx < 4) begin
          chk($sformatf("x%0d_data_%0d", d, idx), {16'd0, xo[d]}, {16'd0, xexp[d][idx]});
          chk($sformatf("x%0d_ovf_%0d", d, idx), {31'd0, x_of[d]}, {31'd0, xovf[d][idx]});
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end
endmodule
